// File: rtl/fetch_stage.sv
// IF stage of a 5-stage pipeline: PC register, IF/ID pipeline register, a
// RUN/STALL/REDIRECT tracking FSM and saturating stall/fetch statistics.
module fetch_stage (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PCWrite,
  input  logic        IFIDWrite,
  input  logic        PCSrc,
  input  logic [31:0] BranchTarget,
  input  logic        Flush,
  output logic [31:0] IMemAddr,
  input  logic [31:0] IMemData,
  output logic [31:0] PCF,
  output logic [31:0] InstructionD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [1:0]  FetchState,
  output logic [15:0] StallCount,
  output logic [15:0] FetchCount,
  output logic        StallTimeout
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_STALL    = 2'b01,
    ST_REDIRECT = 2'b10
  } fetch_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic [31:0]  r_pc_plus4;
  logic         r_valid;
  logic [15:0]  r_stall_cnt;
  logic [15:0]  r_fetch_cnt;
  logic [3:0]   r_consec;
  logic         r_timeout;

  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_target;
  logic         w_stall;
  logic         w_squash;
  logic         w_load;
  logic [3:0]   w_consec_next;
  logic         w_unused_tgt;

  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_target      = {BranchTarget[31:2], 2'b00};
  assign w_unused_tgt  = ^BranchTarget[1:0];
  assign w_stall       = ~PCWrite & ~PCSrc;
  // A redirect always squashes IF/ID, with or without Flush.
  assign w_squash      = Flush | PCSrc;
  assign w_load        = ~w_squash & IFIDWrite;
  assign w_consec_next = w_stall ? sat_inc4(r_consec) : 4'd0;

  // Next-state logic for the fetch tracking FSM.
  always_comb begin
    w_state_next = ST_RUN;
    case (r_state)
      ST_RUN, ST_REDIRECT: begin
        if (PCSrc)        w_state_next = ST_REDIRECT;
        else if (w_stall) w_state_next = ST_STALL;
        else              w_state_next = ST_RUN;
      end
      ST_STALL: begin
        if (PCSrc)        w_state_next = ST_REDIRECT;
        else if (PCWrite) w_state_next = ST_RUN;
        else              w_state_next = ST_STALL;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= ST_RUN;
    else       r_state <= w_state_next;
  end

  // PC, IF/ID register and statistics counters.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pc        <= 32'd0;
      r_instr     <= 32'd0;
      r_pc_plus4  <= 32'd0;
      r_valid     <= 1'b0;
      r_stall_cnt <= 16'd0;
      r_fetch_cnt <= 16'd0;
      r_consec    <= 4'd0;
      r_timeout   <= 1'b0;
    end else begin
      if (PCSrc)        r_pc <= w_target;
      else if (PCWrite) r_pc <= w_pc_plus4;
      else              r_pc <= r_pc;

      if (w_squash) begin
        r_instr    <= 32'd0;
        r_pc_plus4 <= 32'd0;
        r_valid    <= 1'b0;
      end else if (IFIDWrite) begin
        r_instr    <= IMemData;
        r_pc_plus4 <= w_pc_plus4;
        r_valid    <= 1'b1;
      end else begin
        r_instr    <= r_instr;
        r_pc_plus4 <= r_pc_plus4;
        r_valid    <= r_valid;
      end

      r_stall_cnt <= w_stall ? sat_inc16(r_stall_cnt) : r_stall_cnt;
      r_fetch_cnt <= w_load ? sat_inc16(r_fetch_cnt) : r_fetch_cnt;
      r_consec    <= w_consec_next;
      // Sticky until reset once a run of 15 stalls has been seen.
      r_timeout   <= r_timeout | (w_consec_next == 4'd15);
    end
  end

  assign IMemAddr     = r_pc;
  assign PCF          = r_pc;
  assign InstructionD = r_instr;
  assign PCPlus4D     = r_pc_plus4;
  assign ValidD       = r_valid;
  assign FetchState   = r_state;
  assign StallCount   = r_stall_cnt;
  assign FetchCount   = r_fetch_cnt;
  assign StallTimeout = r_timeout;

endmodule
